// File: rtl/chromosome_error_accumulator.sv
// Per-channel mismatch counter for serial chromosome evaluation, with a registered total and done pulse.
// Build option: define ERRSUM_SATURATE_EN to clamp channel counters instead of wrapping.
module chromosome_error_lane #(
  parameter int SUM_WIDTH = 32
) (
  input  logic                 iClock,
  input  logic                 iResetN,
  input  logic                 iZero,
  input  logic                 iInc,
  output logic [SUM_WIDTH-1:0] oSum,
  output logic                 oWrap
);
  // An increment landing on the all-ones value is the overflow event in both build modes.
  assign oWrap = iInc && (oSum == '1);

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN)  oSum <= '0;
    else if (iZero) oSum <= '0;
    else if (iInc) begin
`ifdef ERRSUM_SATURATE_EN
      if (!oWrap) oSum <= oSum + 1'b1;
`else
      oSum <= oSum + 1'b1;
`endif
    end
  end
endmodule

module chromosome_error_accumulator #(
  parameter int CHANNELS         = 8,
  parameter int SUM_WIDTH        = 32,
  parameter int SEQ_DEPTH        = 16,
  parameter int SEQ_IDX_WIDTH    = 4,
  parameter int CYCLES_TO_IGNORE = 5,
  localparam int TOTAL_WIDTH     = SUM_WIDTH + $clog2(CHANNELS)
) (
  input  logic                            iClock,
  input  logic                            iResetN,
  input  logic                            iStart,
  input  logic                            iClear,
  input  logic                            iSampleValid,
  input  logic                            iLast,
  input  logic [SEQ_IDX_WIDTH-1:0]        iCurrentSequence,
  input  logic [SEQ_DEPTH*CHANNELS-1:0]   iExpectedSequence,
  input  logic [CHANNELS-1:0]             iChannelMask,
  input  logic [CHANNELS-1:0]             iChromosomeOutput,
  output logic [CHANNELS*SUM_WIDTH-1:0]   oErrorSums,
  output logic [TOTAL_WIDTH-1:0]          oTotalError,
  output logic                            oBusy,
  output logic                            oDone,
  output logic                            oOverflow
);
  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, DRAIN, HOLD} state_t;

  localparam int IGN_W = $clog2(CYCLES_TO_IGNORE + 2);
  localparam logic [IGN_W-1:0] IGN_LAST = IGN_W'(CYCLES_TO_IGNORE > 0 ? CYCLES_TO_IGNORE - 1 : 0);

  state_t                             state, stateNext;
  logic [IGN_W-1:0]                   ignCnt, ignCntNext;
  logic                               doneNext;
  logic                               zero, accept;
  logic [CHANNELS-1:0]                expWord, inc, wrap;
  logic [CHANNELS-1:0][SUM_WIDTH-1:0] sumArr;
  logic [TOTAL_WIDTH-1:0]             totalNext;

  assign zero   = iStart | iClear;
  assign accept = (state == ACCUM) && iSampleValid && !zero;
  assign oBusy  = (state == SETTLE) || (state == ACCUM) || (state == DRAIN);
  assign oErrorSums = sumArr;

  // Out-of-range indices match no entry, leaving the expected word at zero.
  always_comb begin
    expWord = '0;
    for (int k = 0; k < SEQ_DEPTH; k++)
      if (32'(iCurrentSequence) == k) expWord = iExpectedSequence[k*CHANNELS +: CHANNELS];
  end

  always_comb begin
    stateNext  = state;
    ignCntNext = ignCnt;
    doneNext   = 1'b0;
    if (iStart) begin
      stateNext  = (CYCLES_TO_IGNORE == 0) ? ACCUM : SETTLE;
      ignCntNext = '0;
    end else if (iClear) begin
      stateNext  = IDLE;
      ignCntNext = '0;
    end else begin
      case (state)
        SETTLE: if (iSampleValid) begin
          if (iLast)                   stateNext  = DRAIN;
          else if (ignCnt == IGN_LAST) stateNext  = ACCUM;
          else                         ignCntNext = ignCnt + 1'b1;
        end
        ACCUM:  if (iSampleValid && iLast) stateNext = DRAIN;
        DRAIN: begin
          stateNext = HOLD;
          doneNext  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gLane
    assign inc[c] = accept && iChannelMask[c] && (iChromosomeOutput[c] ^ expWord[c]);
    chromosome_error_lane #(.SUM_WIDTH(SUM_WIDTH)) uLane (
      .iClock (iClock),
      .iResetN(iResetN),
      .iZero  (zero),
      .iInc   (inc[c]),
      .oSum   (sumArr[c]),
      .oWrap  (wrap[c])
    );
  end

  // Total is wide enough for every channel at full scale, so it cannot wrap.
  always_comb begin
    totalNext = '0;
    for (int c = 0; c < CHANNELS; c++) totalNext = totalNext + TOTAL_WIDTH'(sumArr[c]);
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state       <= IDLE;
      ignCnt      <= '0;
      oDone       <= 1'b0;
      oOverflow   <= 1'b0;
      oTotalError <= '0;
    end else begin
      state  <= stateNext;
      ignCnt <= ignCntNext;
      oDone  <= doneNext;
      if (zero) begin
        oOverflow   <= 1'b0;
        oTotalError <= '0;
      end else begin
        oOverflow   <= oOverflow | (|wrap);
        oTotalError <= totalNext;
      end
    end
  end
endmodule

// File: tb/tb_chromosome_error_accumulator.sv
// Directed bench: default instance for settle/clear/reset behaviour, a narrow no-settle instance for mask/index/overflow.
module tb_chromosome_error_accumulator;
  logic         iClock = 0;
  logic         iResetN = 0;
  logic         iStart = 0, iClear = 0, iSampleValid = 0, iLast = 0;
  logic [4:0]   seqIdx = '0;
  logic [127:0] expSeq = '0;
  logic [7:0]   mask = 8'hFF, chromOut = '0;

  logic [255:0] sums0;
  logic [34:0]  total0;
  logic         busy0, done0, ovf0;
  logic [31:0]  sums1;
  logic [6:0]   total1;
  logic         busy1, done1, ovf1;

  int nAsserts = 0;
  int nFails = 0;

  always #5 iClock = ~iClock;

  chromosome_error_accumulator uDut0 (
    .iClock(iClock), .iResetN(iResetN), .iStart(iStart), .iClear(iClear),
    .iSampleValid(iSampleValid), .iLast(iLast), .iCurrentSequence(seqIdx[3:0]),
    .iExpectedSequence(expSeq), .iChannelMask(mask), .iChromosomeOutput(chromOut),
    .oErrorSums(sums0), .oTotalError(total0), .oBusy(busy0), .oDone(done0), .oOverflow(ovf0)
  );

  chromosome_error_accumulator #(.SUM_WIDTH(4), .SEQ_IDX_WIDTH(5), .CYCLES_TO_IGNORE(0)) uDut1 (
    .iClock(iClock), .iResetN(iResetN), .iStart(iStart), .iClear(iClear),
    .iSampleValid(iSampleValid), .iLast(iLast), .iCurrentSequence(seqIdx),
    .iExpectedSequence(expSeq), .iChannelMask(mask), .iChromosomeOutput(chromOut),
    .oErrorSums(sums1), .oTotalError(total1), .oBusy(busy1), .oDone(done1), .oOverflow(ovf1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic startEval();
    iStart = 1;
    step();
    iStart = 0;
  endtask

  task automatic feed(input int n, input bit withLast);
    for (int i = 0; i < n; i++) begin
      iSampleValid = 1;
      iLast = withLast && (i == n - 1);
      step();
    end
    iSampleValid = 0;
    iLast = 0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) expSeq[k*8 +: 8] = (k == 3) ? 8'h00 : 8'hFF;
    step();
    step();
    chk("rst_sums", sums0, 0);
    chk("rst_total", total0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovf", ovf0, 0);
    iResetN = 1;
    step();

    // 10 samples, 5 discarded, 5 counted on every channel
    seqIdx = 5'd3; chromOut = 8'hFF; mask = 8'hFF;
    startEval();
    chk("t1_busy_start", busy0, 1);
    chk("t1_sums_start", sums0, 0);
    feed(10, 1);
    chk("t1_sums", sums0, {8{32'd5}});
    chk("t1_busy_drain", busy0, 1);
    chk("t1_done_drain", done0, 0);
    step();
    chk("t1_done", done0, 1);
    chk("t1_total", total0, 40);
    chk("t1_busy_hold", busy0, 0);
    step();
    chk("t1_done_once", done0, 0);
    chk("t1_total_hold", total0, 40);

    // abort mid-ACCUM
    startEval();
    feed(7, 0);
    chk("clr_sums_pre", sums0, {8{32'd2}});
    iClear = 1; iSampleValid = 1;
    step();
    iClear = 0; iSampleValid = 0;
    chk("clr_sums", sums0, 0);
    chk("clr_total", total0, 0);
    chk("clr_busy", busy0, 0);
    chk("clr_done", done0, 0);
    step();
    chk("clr_done2", done0, 0);
    iStart = 1; iClear = 1;
    step();
    iStart = 0; iClear = 0;
    chk("startclr_busy", busy0, 1);
    chk("startclr_sums", sums0, 0);
    iClear = 1; step(); iClear = 0;

    // no settle window, upper four channels frozen
    mask = 8'h0F; chromOut = 8'hFF; seqIdx = 5'd3;
    startEval();
    feed(4, 1);
    chk("t2_sums", sums1, 32'h0000_4444);
    chk("t2_busy", busy1, 1);
    step();
    chk("t2_done", done1, 1);
    chk("t2_total", total1, 16);

    // index beyond depth compares against zero
    mask = 8'hFF; chromOut = 8'h01; seqIdx = 5'd20;
    startEval();
    feed(1, 1);
    chk("t3_sums", sums1, 32'h0000_0001);
    step();
    chk("t3_total", total1, 1);

    // 17 mismatches into a 4-bit counter
    seqIdx = 5'd3;
    startEval();
    chk("t4_ovf_start", ovf1, 0);
    feed(17, 1);
`ifdef ERRSUM_SATURATE_EN
    chk("t4_sum", sums1, 32'h0000_000F);
    step();
    chk("t4_total", total1, 15);
`else
    chk("t4_sum", sums1, 32'h0000_0001);
    step();
    chk("t4_total", total1, 1);
`endif
    chk("t4_ovf", ovf1, 1);
    startEval();
    chk("t4_ovf_clr", ovf1, 0);
    iClear = 1; step(); iClear = 0;

    // async reset while draining
    chromOut = 8'hFF;
    startEval();
    feed(6, 1);
    chk("t5_busy_drain", busy0, 1);
    chk("t5_sums_drain", sums0, {8{32'd1}});
    #2 iResetN = 0;
    #1;
    chk("t5_sums", sums0, 0);
    chk("t5_total", total0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_done", done0, 0);
    step();
    chk("t5_done2", done0, 0);
    iResetN = 1;
    step();
    chk("t5_done3", done0, 0);
    chk("t5_busy3", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/chromosome_error_accumulator.md
# chromosome_error_accumulator

Parametrised per-channel error accumulator for serial chromosome evaluation. It compares each valid chromosome output word against the expected sequence entry selected by the sequence index, and counts mismatching bits per channel after a settle window. It also produces a pipelined total and signals completion with a done pulse. It sits between the chromosome circuit under evaluation and the fitness/selection logic, and generalises the fixed 8-channel/16-entry error summer.

## Interface
- CHANNELS, 8, number of output bits compared (channels)
- SUM_WIDTH, 32, width of each per-channel error counter
- SEQ_DEPTH, 16, number of expected-sequence entries
- SEQ_IDX_WIDTH, 4, width of sequence index (≥ $clog2(SEQ_DEPTH))
- CYCLES_TO_IGNORE, 5, valid samples discarded after start (0 allowed)
- Localparam TOTAL_WIDTH = SUM_WIDTH + $clog2(CHANNELS)

Ports:
- iClock  in  1  sole clock, rising edge
- iResetN  in  1  asynchronous, active-low reset
- iStart  in  1  start new evaluation; clears sums and overflow
- iClear  in  1  return to IDLE and zero results
- iSampleValid  in  1  iChromosomeOutput valid this cycle
- iLast  in  1  qualifies final sample (only with iSampleValid)
- iCurrentSequence  in  SEQ_IDX_WIDTH  expected-sequence index
- iExpectedSequence  in  SEQ_DEPTH*CHANNELS  entry k at [k*CHANNELS +: CHANNELS]
- iChannelMask  in  CHANNELS  1 = channel counted, 0 = channel frozen
- iChromosomeOutput  in  CHANNELS  chromosome output bits
- oErrorSums  out  CHANNELS*SUM_WIDTH  channel c at [c*SUM_WIDTH +: SUM_WIDTH]
- oTotalError  out  TOTAL_WIDTH  sum of all oErrorSums
- oBusy  out  1  high in SETTLE, ACCUM, DRAIN
- oDone  out  1  single-cycle pulse on DRAIN→HOLD
- oOverflow  out  1  sticky; some channel counter hit its limit

## Operation
- States: IDLE, SETTLE, ACCUM, DRAIN, HOLD. Reset → IDLE, all outputs 0.
- Priority each cycle: iStart > iClear > sample handling.
- iStart (any state): zero sums, total, overflow and ignore counter. Next state is SETTLE, or ACCUM if CYCLES_TO_IGNORE = 0. Any sample presented in the same cycle is ignored.
- SETTLE: each iSampleValid increments the ignore counter. After CYCLES_TO_IGNORE valid samples, go to ACCUM. Sums stay unchanged. iSampleValid&iLast in SETTLE → DRAIN with zero sums.
- ACCUM: on iSampleValid, for each channel c with iChannelMask[c]=1, sum[c] += iChromosomeOutput[c] ^ expected[c]. iSampleValid&iLast → DRAIN (the last sample is counted).
- Expected word = entry iCurrentSequence. An index ≥ SEQ_DEPTH selects all-zero expected.
- DRAIN: one cycle for the total to settle. Then go to HOLD and pulse oDone.
- HOLD: results stable. iClear → IDLE with zeroed outputs. Samples are ignored.
- IDLE: samples ignored. iClear has no further effect.
- iClear while busy: abort to IDLE, zero everything, no oDone.
- Counter limit: see Configuration. oOverflow is set when any enabled channel increments at value 2^SUM_WIDTH−1.

## Timing
- Sample accepted at edge t → oErrorSums updated after edge t → oTotalError reflects it after edge t+1.
- iLast at edge t: DRAIN during cycle t..t+1. oDone is high for exactly one cycle after edge t+1, coincident with the final oTotalError. oBusy falls in that same cycle.
- oTotalError is a registered full-width adder tree over the registered sums. It never wraps.
- iStart and iClear take effect at the next edge. Outputs are zero from the following cycle.
- Async reset mid-operation: immediate zeroing, IDLE, no oDone.
- Back-to-back iStart while busy restarts cleanly. The settle window restarts from 0.

## Configuration
- ERRSUM_SATURATE_EN defined: per-channel counters clamp at 2^SUM_WIDTH−1 and oOverflow is set.
- Not defined: counters wrap modulo 2^SUM_WIDTH. oOverflow is still set on the wrapping increment.

## Test plan
- Defaults, iStart, then 10 valid samples with output 0xFF and expected 0x00 at index 3, iLast on the 10th → each sum = 5, oTotalError = 40, oDone one cycle, 2 cycles after the last sample.
- CYCLES_TO_IGNORE=0, iChannelMask=0x0F, 4 samples all mismatching → channels 0–3 = 4, channels 4–7 = 0, total 16.
- iCurrentSequence=20 (> SEQ_DEPTH), output 0x01 → only channel 0 increments.
- SUM_WIDTH=4, 17 mismatches on channel 0: with macro, sum = 15; without macro, sum = 1. oOverflow = 1 in both.
- iClear asserted mid-ACCUM → outputs 0, state IDLE, no oDone. Then iStart with iClear in the same cycle → SETTLE entered.
- iResetN low during DRAIN → all outputs 0 immediately. oDone never pulses.
